// File: rtl/flip_iteration_scheduler.sv
// rtl/flip_iteration_scheduler.sv - issues candidate spins, retires their energies in order and tracks the best result.
module flip_iteration_scheduler #(
  parameter int DATASPIN         = 256,
  parameter int ENERGY_TOTAL_BIT = 32,
  parameter int ITER_CNT_BIT     = 16,
  parameter int SPIN_DEPTH       = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               start_i,
  input  logic [ITER_CNT_BIT-1:0]            iter_num_i,
  input  logic                               abort_i,
  input  logic                               cand_valid_i,
  input  logic [DATASPIN-1:0]                cand_spin_i,
  output logic                               cand_ready_o,
  output logic                               spin_valid_o,
  output logic [DATASPIN-1:0]                spin_o,
  input  logic                               spin_ready_i,
  input  logic                               energy_valid_i,
  input  logic signed [ENERGY_TOTAL_BIT-1:0] energy_i,
  output logic                               energy_ready_o,
  output logic                               flush_o,
  output logic                               en_comparison_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic [ITER_CNT_BIT-1:0]            iter_cnt_o,
  output logic signed [ENERGY_TOTAL_BIT-1:0] best_energy_o,
  output logic [DATASPIN-1:0]                best_spin_o
);

  localparam int PTR_W = (SPIN_DEPTH > 1) ? $clog2(SPIN_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                              state_q, state_d;
  logic [ITER_CNT_BIT-1:0]             target_q, target_d;
  logic [ITER_CNT_BIT-1:0]             issued_q, issued_d;
  logic [ITER_CNT_BIT-1:0]             retired_q, retired_d;
  logic [ITER_CNT_BIT-1:0]             outstanding;
  logic                                best_valid_q, best_valid_d;
  logic signed [ENERGY_TOTAL_BIT-1:0]  best_energy_q, best_energy_d;
  logic [DATASPIN-1:0]                 best_spin_q, best_spin_d;
  logic [DATASPIN-1:0]                 tag_mem_q [SPIN_DEPTH];
  logic [PTR_W-1:0]                    wr_ptr_q, rd_ptr_q;
  logic                                in_run, active, issue_allow;
  logic                                issue_fire, retire_fire, start_fire;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SPIN_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reset and abort gate every handshake combinationally so nothing slips through that cycle.
  assign in_run      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign active      = in_run && !rst_i && !abort_i;
  assign outstanding = issued_q - retired_q;
  assign issue_allow = (state_q == S_RUN) && !rst_i && !abort_i && (issued_q < target_q)
                       && (outstanding < ITER_CNT_BIT'(SPIN_DEPTH));

  assign spin_valid_o    = cand_valid_i && issue_allow;
  assign spin_o          = cand_spin_i;
  assign cand_ready_o    = spin_ready_i && issue_allow;
  assign energy_ready_o  = active && (outstanding != '0);
  assign issue_fire      = spin_valid_o && spin_ready_i;
  assign retire_fire     = energy_valid_i && energy_ready_o;
  assign start_fire      = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i && !abort_i && !rst_i;
  assign flush_o         = !rst_i && (abort_i || start_fire);
  assign en_comparison_o = best_valid_q && in_run && !rst_i;
  assign busy_o          = in_run && !rst_i;
  assign done_o          = (state_q == S_DONE) && !rst_i;
  assign iter_cnt_o      = retired_q;
  assign best_energy_o   = best_energy_q;
  assign best_spin_o     = best_spin_q;

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    issued_d      = issued_q;
    retired_d     = retired_q;
    best_valid_d  = best_valid_q;
    best_energy_d = best_energy_q;
    best_spin_d   = best_spin_q;
    if (start_fire) begin
      target_d     = iter_num_i;
      issued_d     = '0;
      retired_d    = '0;
      best_valid_d = 1'b0;
      state_d      = (iter_num_i != '0) ? S_RUN : S_DONE;
    end else if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      if (issue_fire) issued_d = issued_q + 1'b1;
      if (retire_fire) begin
        retired_d = retired_q + 1'b1;
        // Strict compare: an equal energy never displaces the earlier spin.
        if (!best_valid_q || (energy_i < best_energy_q)) begin
          best_energy_d = energy_i;
          best_spin_d   = tag_mem_q[rd_ptr_q];
          best_valid_d  = 1'b1;
        end
      end
      case (state_q)
        S_RUN: begin
          if (retired_d == target_q)     state_d = S_DONE;
          else if (issued_d == target_q) state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if (retired_d == target_q) state_d = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      target_q      <= '0;
      issued_q      <= '0;
      retired_q     <= '0;
      best_valid_q  <= 1'b0;
      best_energy_q <= '0;
      best_spin_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      issued_q      <= issued_d;
      retired_q     <= retired_d;
      best_valid_q  <= best_valid_d;
      best_energy_q <= best_energy_d;
      best_spin_q   <= best_spin_d;
      if (abort_i || start_fire) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (issue_fire)  wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (retire_fire) rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

  // Tag storage carries data only; validity is tracked by the pointers and counters.
  always_ff @(posedge clk_i) begin
    if (issue_fire) tag_mem_q[wr_ptr_q] <= cand_spin_i;
  end

endmodule

// File: tb/tb_flip_iteration_scheduler.sv
// tb/tb_flip_iteration_scheduler.sv - directed self-checking bench for flip_iteration_scheduler.
module tb_flip_iteration_scheduler;

  localparam int DS = 16;
  localparam int EB = 32;
  localparam int IB = 16;

  logic                 clk_i = 1'b0;
  logic                 rst_i, start_i, abort_i;
  logic [IB-1:0]        iter_num_i;
  logic                 cand_valid_i, cand_ready_o;
  logic [DS-1:0]        cand_spin_i;
  logic                 spin_valid_o, spin_ready_i;
  logic [DS-1:0]        spin_o;
  logic                 energy_valid_i, energy_ready_o;
  logic signed [EB-1:0] energy_i;
  logic                 flush_o, en_comparison_o, busy_o, done_o;
  logic [IB-1:0]        iter_cnt_o;
  logic signed [EB-1:0] best_energy_o;
  logic [DS-1:0]        best_spin_o;

  int checks   = 0;
  int failures = 0;
  int iss, ret, flush_cnt;

  logic [DS-1:0]        spin_tab [8];
  logic signed [EB-1:0] en_tab   [8];

  flip_iteration_scheduler #(
    .DATASPIN(DS), .ENERGY_TOTAL_BIT(EB), .ITER_CNT_BIT(IB), .SPIN_DEPTH(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .iter_num_i(iter_num_i),
    .abort_i(abort_i), .cand_valid_i(cand_valid_i), .cand_spin_i(cand_spin_i),
    .cand_ready_o(cand_ready_o), .spin_valid_o(spin_valid_o), .spin_o(spin_o),
    .spin_ready_i(spin_ready_i), .energy_valid_i(energy_valid_i), .energy_i(energy_i),
    .energy_ready_o(energy_ready_o), .flush_o(flush_o), .en_comparison_o(en_comparison_o),
    .busy_o(busy_o), .done_o(done_o), .iter_cnt_o(iter_cnt_o),
    .best_energy_o(best_energy_o), .best_spin_o(best_spin_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a run of n iterations with always-valid spins/energies taken from the tables;
  // returns once done_o is seen or stop_ret energies have been retired.
  task automatic run_iter(input int n, input int stop_ret);
    int cyc;
    iss = 0; ret = 0; flush_cnt = 0;
    @(negedge clk_i);
    start_i = 1'b1; iter_num_i = IB'(n); cand_valid_i = 1'b0; energy_valid_i = 1'b0;
    #1 check("start_flush", flush_o, 1'b1);
    for (cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (done_o || ret == stop_ret) begin
        cand_valid_i = 1'b0; energy_valid_i = 1'b0;
        break;
      end
      cand_valid_i = 1'b1; cand_spin_i = spin_tab[iss % 8];
      energy_valid_i = 1'b1; energy_i = en_tab[ret % 8];
      #1;
      if (flush_o) flush_cnt++;
      if (spin_valid_o && spin_ready_i) iss++;
      if (energy_valid_i && energy_ready_o) ret++;
    end
    if (cyc >= 200) check("run_timeout", 1'b0, 1'b1);
    check("run_no_extra_flush", flush_cnt, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) spin_tab[i] = DS'(16'hA000 + i * 16'h0111);
    rst_i = 1'b1; start_i = 1'b1; abort_i = 1'b0; iter_num_i = 16'd3;
    cand_valid_i = 1'b1; cand_spin_i = '0; spin_ready_i = 1'b1;
    energy_valid_i = 1'b1; energy_i = 32'sd5;
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_flush", flush_o, 1'b0);
    check("rst_spin_valid", spin_valid_o, 1'b0);
    check("rst_energy_ready", energy_ready_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_best_energy", best_energy_o, 32'd0);
    check("rst_iter_cnt", iter_cnt_o, 16'd0);
    rst_i = 1'b0; start_i = 1'b0; cand_valid_i = 1'b0; energy_valid_i = 1'b0;

    // Four spins, energies 10,-5,3,-5: the later -5 ties and must not replace B.
    en_tab[0] = 32'sd10; en_tab[1] = -32'sd5; en_tab[2] = 32'sd3; en_tab[3] = -32'sd5;
    run_iter(4, -1);
    #1;
    check("t1_done", done_o, 1'b1);
    check("t1_busy", busy_o, 1'b0);
    check("t1_iter_cnt", iter_cnt_o, 16'd4);
    check("t1_best_energy", best_energy_o, -32'sd5);
    check("t1_best_spin", best_spin_o, spin_tab[1]);
    check("t1_issued", iss, 4);

    // Signed extremes, started from DONE.
    en_tab[0] = 32'sh7fffffff; en_tab[1] = 32'sh80000000; en_tab[2] = 32'sd0;
    run_iter(3, -1);
    #1;
    check("t2_best_energy", best_energy_o, 32'sh80000000);
    check("t2_best_spin", best_spin_o, spin_tab[1]);
    check("t2_iter_cnt", iter_cnt_o, 16'd3);

    // Order through the tag FIFO under continuous same-cycle issue and retire.
    en_tab[0] = 32'sd5; en_tab[1] = 32'sd4; en_tab[2] = -32'sd3; en_tab[3] = 32'sd8; en_tab[4] = -32'sd3;
    run_iter(5, -1);
    #1;
    check("t3_best_energy", best_energy_o, -32'sd3);
    check("t3_best_spin", best_spin_o, spin_tab[2]);
    check("t3_iter_cnt", iter_cnt_o, 16'd5);

    // Outstanding limit: with no energies returned only two spins issue.
    @(negedge clk_i);
    start_i = 1'b1; iter_num_i = 16'd4;
    #1;
    iss = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      start_i = 1'b0; cand_valid_i = 1'b1; cand_spin_i = spin_tab[iss % 8]; energy_valid_i = 1'b0;
      #1;
      if (spin_valid_o && spin_ready_i) iss++;
    end
    check("t4_issued", iss, 2);
    check("t4_cand_ready_stall", cand_ready_o, 1'b0);
    check("t4_en_cmp_before", en_comparison_o, 1'b0);
    @(negedge clk_i);
    energy_valid_i = 1'b1; energy_i = 32'sd1;
    #1;
    check("t4_energy_ready", energy_ready_o, 1'b1);
    check("t4_cand_ready_same", cand_ready_o, 1'b0);
    @(negedge clk_i);
    energy_valid_i = 1'b0;
    #1;
    check("t4_cand_ready_resume", cand_ready_o, 1'b1);
    check("t4_en_cmp_after", en_comparison_o, 1'b1);
    check("t4_best_spin", best_spin_o, spin_tab[0]);
    @(negedge clk_i);
    cand_valid_i = 1'b0; abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;

    // Zero iterations go straight to DONE.
    @(negedge clk_i);
    start_i = 1'b1; iter_num_i = 16'd0; cand_valid_i = 1'b1;
    #1;
    check("t5_flush", flush_o, 1'b1);
    check("t5_spin_valid", spin_valid_o, 1'b0);
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    check("t5_done", done_o, 1'b1);
    check("t5_iter_cnt", iter_cnt_o, 16'd0);
    check("t5_spin_valid_done", spin_valid_o, 1'b0);
    cand_valid_i = 1'b0;

    // Abort after two retirements keeps the best result, then a fresh run starts clean.
    en_tab[0] = 32'sd6; en_tab[1] = 32'sd2; en_tab[2] = -32'sd9; en_tab[3] = -32'sd9; en_tab[4] = -32'sd9;
    run_iter(5, 2);
    abort_i = 1'b1; energy_valid_i = 1'b1; energy_i = -32'sd9;
    #1;
    check("t6_abort_flush", flush_o, 1'b1);
    check("t6_abort_energy_ready", energy_ready_o, 1'b0);
    check("t6_abort_spin_valid", spin_valid_o, 1'b0);
    @(negedge clk_i);
    abort_i = 1'b0; energy_valid_i = 1'b0;
    #1;
    check("t6_idle_busy", busy_o, 1'b0);
    check("t6_idle_done", done_o, 1'b0);
    check("t6_iter_cnt", iter_cnt_o, 16'd2);
    check("t6_best_energy", best_energy_o, 32'sd2);
    check("t6_best_spin", best_spin_o, spin_tab[1]);
    en_tab[0] = 32'sd50;
    run_iter(1, -1);
    #1;
    check("t6_restart_done", done_o, 1'b1);
    check("t6_restart_best", best_energy_o, 32'sd50);
    check("t6_restart_spin", best_spin_o, spin_tab[0]);
    check("t6_restart_cnt", iter_cnt_o, 16'd1);

    // Reset in the middle of DRAIN discards everything.
    @(negedge clk_i);
    start_i = 1'b1; iter_num_i = 16'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      start_i = 1'b0; cand_valid_i = 1'b1; cand_spin_i = spin_tab[3 + i]; energy_valid_i = 1'b0;
    end
    cand_valid_i = 1'b0;
    #1 check("t7_drain_busy", busy_o, 1'b1);
    @(negedge clk_i);
    energy_valid_i = 1'b1; energy_i = 32'sd9;
    @(negedge clk_i);
    energy_valid_i = 1'b0;
    #1 check("t7_partial_best", best_energy_o, 32'sd9);
    @(negedge clk_i);
    rst_i = 1'b1; energy_valid_i = 1'b1; energy_i = -32'sd7;
    #1 check("t7_rst_energy_ready", energy_ready_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("t7_busy", busy_o, 1'b0);
    check("t7_energy_ready", energy_ready_o, 1'b0);
    check("t7_best_energy", best_energy_o, 32'd0);
    check("t7_best_spin", best_spin_o, 16'd0);
    check("t7_en_cmp", en_comparison_o, 1'b0);
    @(negedge clk_i);
    #1 check("t7_late_energy_ignored", iter_cnt_o, 16'd0);
    energy_valid_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
